// File: rtl/axis_host_src_arbiter_pkg.sv
// Shared types and default widths for the host source stream arbiter.
package lynxTypes;

  localparam int N_STRM_AXI    = 4;
  localparam int AXI_DATA_BITS = 512;
  localparam int PID_BITS      = 6;
  localparam int ARB_MAX_SRC   = 16;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_state_t;

  // Index width for n sources; a single source still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_host_src_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module axis_rr_pick
  import lynxTypes::*;
#(
  parameter int N_SRC    = N_STRM_AXI,
  parameter int IDX_BITS = idx_bits(N_SRC)
) (
  input  logic [N_SRC-1:0]    req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [IDX_BITS-1:0] idx,
  output logic                found
);

  // Two passes: the upper range [ptr, N_SRC) wins, then the wrap-around from 0.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N_SRC; j++) begin
      if (!found && req[j] && (IDX_BITS'(j) >= ptr)) begin
        idx   = IDX_BITS'(j);
        found = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N_SRC; j++) begin
      if (!found && req[j]) begin
        idx   = IDX_BITS'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_host_src_arbiter.sv
// Packet-level round-robin merge of N_SRC AXI4SR host source streams onto one.
// Optional per-source packet counters are built when ARB_STATS_EN is defined.
module axis_host_src_arbiter
  import lynxTypes::*;
#(
  parameter int N_SRC     = N_STRM_AXI,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter int ID_BITS   = PID_BITS,
  localparam int IDX_BITS = idx_bits(N_SRC),
  localparam int KEEP_BITS = DATA_BITS / 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [N_SRC*DATA_BITS-1:0]   s_tdata,
  input  logic [N_SRC*KEEP_BITS-1:0]   s_tkeep,
  input  logic [N_SRC*ID_BITS-1:0]     s_tid,
  input  logic [N_SRC-1:0]             s_tlast,
  input  logic [N_SRC-1:0]             s_tvalid,
  output logic [N_SRC-1:0]             s_tready,
  output logic [DATA_BITS-1:0]         m_tdata,
  output logic [KEEP_BITS-1:0]         m_tkeep,
  output logic [ID_BITS-1:0]           m_tid,
  output logic                         m_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [IDX_BITS-1:0]          grant_idx,
  output logic                         busy
`ifdef ARB_STATS_EN
  ,
  output logic [N_SRC*32-1:0]          stat_pkts,
  input  logic                         stat_clr
`endif
);

  arb_state_t          state;
  logic [IDX_BITS-1:0] rr_ptr;
  logic [IDX_BITS-1:0] pick_idx;
  logic                pick_found;
  logic                accept;
  logic                sel_last;

  logic [DATA_BITS-1:0] src_data [N_SRC];
  logic [KEEP_BITS-1:0] src_keep [N_SRC];
  logic [ID_BITS-1:0]   src_id   [N_SRC];

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_data[i] = s_tdata[i*DATA_BITS +: DATA_BITS];
      src_keep[i] = s_tkeep[i*KEEP_BITS +: KEEP_BITS];
      src_id[i]   = s_tid[i*ID_BITS +: ID_BITS];
    end
  end

  axis_rr_pick #(
    .N_SRC    (N_SRC),
    .IDX_BITS (IDX_BITS)
  ) u_pick (
    .req   (s_tvalid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Only the granted source sees ready, and only when the output slot frees up.
  always_comb begin
    s_tready = '0;
    if (state == ST_BUSY) begin
      s_tready[grant_idx] = !m_tvalid || m_tready;
    end
  end

  assign accept   = s_tvalid[grant_idx] && s_tready[grant_idx];
  assign sel_last = s_tlast[grant_idx];

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tid     <= '0;
      m_tlast   <= 1'b0;
    end else begin
      if (accept) begin
        m_tdata  <= src_data[grant_idx];
        m_tkeep  <= src_keep[grant_idx];
        m_tid    <= src_id[grant_idx];
        m_tlast  <= sel_last;
        m_tvalid <= 1'b1;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            busy      <= 1'b1;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && sel_last) begin
            rr_ptr <= (grant_idx == IDX_BITS'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] pkt_cnt [N_SRC];

  // Clear takes priority over a packet completing in the same cycle.
  always_ff @(posedge aclk) begin
    if (areset || stat_clr) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        pkt_cnt[i] <= '0;
      end
    end else if (accept && sel_last) begin
      pkt_cnt[grant_idx] <= pkt_cnt[grant_idx] + 32'd1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      stat_pkts[i*32 +: 32] = pkt_cnt[i];
    end
  end
`endif

endmodule
